periph_poll_ctrl: RTL and testbench

//  Bus-master sequencer that offloads a status-polled peripheral read from the EX stage.
//  On start: writes the peripheral's CTRL register, polls STATUS until busy bit0 clears,

---
 rtl/periph_poll_ctrl_if.sv | 29 ++
 rtl/periph_poll_ctrl.sv | 151 +++++++++++++++
 tb/tb_periph_poll_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/periph_poll_ctrl_if.sv
// EX-side handshake and memory-mapped bus signals for periph_poll_ctrl.
// master: the sequencer; slave: the EX stage / bus fabric side.
interface periph_poll_ctrl_if;
  logic        start_i;
  logic [4:0]  reg_waddr_i;
  logic        busy_o;
  logic        ready_o;
  logic        err_o;
  logic [31:0] rdata_o;
  logic [4:0]  reg_waddr_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_grant_i;

  modport master (
    input  start_i, reg_waddr_i, bus_rdata_i, bus_grant_i,
    output busy_o, ready_o, err_o, rdata_o, reg_waddr_o,
           bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o
  );

  modport slave (
    output start_i, reg_waddr_i, bus_rdata_i, bus_grant_i,
    input  busy_o, ready_o, err_o, rdata_o, reg_waddr_o,
           bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o
  );
endinterface

// File: rtl/periph_poll_ctrl.sv
// Sequencer: write CTRL, poll STATUS until bit0 clears, read DATA, return it to EX.
// Optional abort-on-timeout enabled by defining PERIPH_POLL_TIMEOUT_EN.
module periph_poll_ctrl #(
  parameter logic [31:0] BASE_ADDR      = 32'h7004_0000,
  parameter int unsigned POLL_INTERVAL  = 4
`ifdef PERIPH_POLL_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input logic                clk,
  input logic                rst,
  periph_poll_ctrl_if.master pif
);

  localparam int unsigned IW = $clog2(POLL_INTERVAL + 1);
  localparam logic [IW-1:0] I_TERM = IW'(POLL_INTERVAL - 1);
`ifdef PERIPH_POLL_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_TERM = TW'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE, ST_CTRL, ST_POLL, ST_WAIT, ST_DATA, ST_DONE
`ifdef PERIPH_POLL_TIMEOUT_EN
    , ST_ERR
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [IW-1:0] icnt_q, icnt_d;
  logic        busy_q, busy_d, ready_q, ready_d, err_q, err_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [4:0]  waddr_q, waddr_d;
  logic        xfer;
`ifdef PERIPH_POLL_TIMEOUT_EN
  logic [TW-1:0] tcnt_q, tcnt_d;
`endif

  assign xfer = req_q & pif.bus_grant_i;

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      icnt_q  <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      waddr_q <= '0;
`ifdef PERIPH_POLL_TIMEOUT_EN
      tcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      icnt_q  <= icnt_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      waddr_q <= waddr_d;
`ifdef PERIPH_POLL_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
`endif
    end
  end

  // Next state; bus/handshake outputs are decoded from the next state so they
  // line up with the state they belong to and stay stable until the grant.
  always_comb begin
    state_d = state_q;
    icnt_d  = icnt_q;
    rdata_d = rdata_q;
    waddr_d = waddr_q;

    unique case (state_q)
      ST_IDLE: if (pif.start_i) begin
        waddr_d = pif.reg_waddr_i;
        state_d = ST_CTRL;
      end
      ST_CTRL: if (xfer) state_d = ST_POLL;
      ST_POLL: if (xfer) begin
        if (!pif.bus_rdata_i[0]) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_WAIT;
          icnt_d  = '0;
        end
      end
      ST_WAIT: if (icnt_q == I_TERM) state_d = ST_POLL;
               else icnt_d = icnt_q + IW'(1);
      ST_DATA: if (xfer) begin
        rdata_d = pif.bus_rdata_i;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef PERIPH_POLL_TIMEOUT_EN
    // Timeout overrides any transition, including a completing grant
    tcnt_d = tcnt_q;
    if (state_q == ST_IDLE && pif.start_i) begin
      tcnt_d = '0;
    end else if (state_q inside {ST_CTRL, ST_POLL, ST_WAIT, ST_DATA}) begin
      if (tcnt_q == T_TERM) begin
        state_d = ST_ERR;
        rdata_d = rdata_q;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
    end
`endif

    busy_d  = state_d inside {ST_CTRL, ST_POLL, ST_WAIT, ST_DATA};
    req_d   = state_d inside {ST_CTRL, ST_POLL, ST_DATA};
    we_d    = (state_d == ST_CTRL);
    wdata_d = (state_d == ST_CTRL) ? 32'h1 : 32'h0;
    ready_d = (state_d == ST_DONE);
`ifdef PERIPH_POLL_TIMEOUT_EN
    err_d   = (state_d == ST_ERR);
`else
    err_d   = 1'b0;
`endif
    case (state_d)
      ST_CTRL: addr_d = BASE_ADDR + 32'h4;
      ST_POLL: addr_d = BASE_ADDR;
      ST_DATA: addr_d = BASE_ADDR + 32'h8;
      default: addr_d = 32'h0;
    endcase
  end

  assign pif.busy_o      = busy_q;
  assign pif.ready_o     = ready_q;
  assign pif.err_o       = err_q;
  assign pif.rdata_o     = rdata_q;
  assign pif.reg_waddr_o = waddr_q;
  assign pif.bus_req_o   = req_q;
  assign pif.bus_we_o    = we_q;
  assign pif.bus_addr_o  = addr_q;
  assign pif.bus_wdata_o = wdata_q;

endmodule

// File: tb/tb_periph_poll_ctrl.sv
// Scoreboard bench for periph_poll_ctrl: directed scenarios push expected bus
// transfers and responses; a negedge monitor pops and compares them.
module tb_periph_poll_ctrl;
  localparam logic [31:0] BASE = 32'h7004_0000;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          rel;
  } bus_exp_t;

  typedef struct {
    logic        is_err;
    logic [31:0] rdata;
    logic [4:0]  waddr;
    int          rel;
  } rsp_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  periph_poll_ctrl_if pif();

  periph_poll_ctrl #(
    .BASE_ADDR(BASE),
    .POLL_INTERVAL(4)
`ifdef PERIPH_POLL_TIMEOUT_EN
    , .TIMEOUT_CYCLES(32)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .pif(pif)
  );

  bus_exp_t bus_q[$];
  rsp_exp_t rsp_q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;
  int status_reads = 0;
  int busy_until = 0;
  logic [31:0] data_val = 32'h0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Peripheral model: STATUS busy for a set number of reads, DATA returns data_val
  always_comb begin
    if (pif.bus_addr_o == BASE)
      pif.bus_rdata_i = (status_reads < busy_until) ? 32'h1 : 32'h0;
    else if (pif.bus_addr_o == BASE + 32'h8)
      pif.bus_rdata_i = data_val;
    else
      pif.bus_rdata_i = 32'h0;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && pif.bus_req_o && pif.bus_grant_i && !pif.bus_we_o && pif.bus_addr_o == BASE)
      status_reads <= status_reads + 1;
  end

  always @(negedge clk) begin
    bus_exp_t be;
    rsp_exp_t re;
    if (!rst) begin
      if (pif.bus_req_o && pif.bus_grant_i) begin
        if (bus_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_bus: got addr %h we %b, expected none", pif.bus_addr_o, pif.bus_we_o);
        end else begin
          be = bus_q.pop_front();
          check("bus_we", 32'(pif.bus_we_o), 32'(be.we));
          check("bus_addr", pif.bus_addr_o, be.addr);
          check("bus_wdata", pif.bus_wdata_o, be.wdata);
          check("bus_latency", 32'(cyc - start_cyc), 32'(be.rel));
        end
      end
      if (pif.ready_o || pif.err_o) begin
        if (rsp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_rsp: got ready %b err %b, expected none", pif.ready_o, pif.err_o);
        end else begin
          re = rsp_q.pop_front();
          check("rsp_err", 32'(pif.err_o), 32'(re.is_err));
          check("rsp_ready", 32'(pif.ready_o), 32'(!re.is_err));
          check("rsp_rdata", pif.rdata_o, re.rdata);
          check("rsp_waddr", 32'(pif.reg_waddr_o), 32'(re.waddr));
          check("rsp_busy", 32'(pif.busy_o), 32'h0);
          check("rsp_latency", 32'(cyc - start_cyc), 32'(re.rel));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bus(input logic we, input logic [31:0] addr, input int rel);
    bus_exp_t e;
    e.we = we; e.addr = addr; e.wdata = we ? 32'h1 : 32'h0; e.rel = rel;
    bus_q.push_back(e);
  endtask

  task automatic push_rsp(input logic is_err, input logic [31:0] rdata, input logic [4:0] wa, input int rel);
    rsp_exp_t e;
    e.is_err = is_err; e.rdata = rdata; e.waddr = wa; e.rel = rel;
    rsp_q.push_back(e);
  endtask

  // Full happy-path expectation with no busy polls and grant always high
  task automatic push_simple(input logic [31:0] d, input logic [4:0] wa);
    push_bus(1'b1, BASE + 32'h4, 1);
    push_bus(1'b0, BASE, 2);
    push_bus(1'b0, BASE + 32'h8, 3);
    push_rsp(1'b0, d, wa, 4);
  endtask

  task automatic do_start(input logic [4:0] wa);
    pif.start_i = 1'b1;
    pif.reg_waddr_i = wa;
    start_cyc = cyc;
    step();
    pif.start_i = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int max_cyc);
    int n = 0;
    while ((rsp_q.size() != 0 || bus_q.size() != 0) && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    tests++;
    if (rsp_q.size() != 0 || bus_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: got %0d bus/%0d rsp pending, expected 0", nm, bus_q.size(), rsp_q.size());
      bus_q.delete();
      rsp_q.delete();
    end
    repeat (4) step();
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_busy"}, 32'(pif.busy_o), 32'h0);
    check({nm, "_ready"}, 32'(pif.ready_o), 32'h0);
    check({nm, "_err"}, 32'(pif.err_o), 32'h0);
    check({nm, "_req"}, 32'(pif.bus_req_o), 32'h0);
    check({nm, "_we"}, 32'(pif.bus_we_o), 32'h0);
    check({nm, "_addr"}, pif.bus_addr_o, 32'h0);
    check({nm, "_wdata"}, pif.bus_wdata_o, 32'h0);
    check({nm, "_rdata"}, pif.rdata_o, 32'h0);
    check({nm, "_waddr"}, 32'(pif.reg_waddr_o), 32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pif.start_i = 1'b0;
    pif.reg_waddr_i = 5'd0;
    pif.bus_grant_i = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check_reset_outputs("reset");
    step();
    rst = 1'b0;
    step();

    // 1: immediate ready, grant high
    pif.bus_grant_i = 1'b1;
    busy_until = status_reads;
    data_val = 32'hDEAD_BEEF;
    push_simple(32'hDEAD_BEEF, 5'd7);
    do_start(5'd7);
    wait_idle("t1", 50);

    // 2: three busy polls, reads spaced 5 cycles apart
    busy_until = status_reads + 3;
    data_val = 32'hCAFE_0001;
    push_bus(1'b1, BASE + 32'h4, 1);
    for (int r = 2; r <= 17; r += 5) push_bus(1'b0, BASE, r);
    push_bus(1'b0, BASE + 32'h8, 18);
    push_rsp(1'b0, 32'hCAFE_0001, 5'd9, 19);
    do_start(5'd9);
    wait_idle("t2", 60);

    // 3: grant withheld for 6 cycles in CTRL
    pif.bus_grant_i = 1'b0;
    busy_until = status_reads;
    data_val = 32'h0BAD_F00D;
    push_bus(1'b1, BASE + 32'h4, 7);
    push_bus(1'b0, BASE, 8);
    push_bus(1'b0, BASE + 32'h8, 9);
    push_rsp(1'b0, 32'h0BAD_F00D, 5'd17, 10);
    do_start(5'd17);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("stall_req", 32'(pif.bus_req_o), 32'h1);
      check("stall_we", 32'(pif.bus_we_o), 32'h1);
      check("stall_addr", pif.bus_addr_o, BASE + 32'h4);
      check("stall_wdata", pif.bus_wdata_o, 32'h1);
      step();
    end
    pif.bus_grant_i = 1'b1;
    wait_idle("t3", 50);

    // 4: second start during POLL is ignored
    busy_until = status_reads;
    data_val = 32'h5555_AAAA;
    push_simple(32'h5555_AAAA, 5'd12);
    do_start(5'd12);
    step();
    pif.start_i = 1'b1;
    pif.reg_waddr_i = 5'd3;
    step();
    pif.start_i = 1'b0;
    wait_idle("t4", 50);
    check("t4_waddr_hold", 32'(pif.reg_waddr_o), 32'd12);

    // 5: reset while in WAIT aborts silently; then a fresh start completes
    busy_until = status_reads + 100;
    data_val = 32'h0000_0000;
    push_bus(1'b1, BASE + 32'h4, 1);
    push_bus(1'b0, BASE, 2);
    do_start(5'd22);
    step();
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check_reset_outputs("midrst");
    step();
    rst = 1'b0;
    repeat (3) step();
    check("t5_drained", 32'(bus_q.size()), 32'h0);
    busy_until = status_reads;
    data_val = 32'h1234_5678;
    push_simple(32'h1234_5678, 5'd21);
    do_start(5'd21);
    wait_idle("t5", 50);

`ifdef PERIPH_POLL_TIMEOUT_EN
    // 6: STATUS stuck busy, error pulse 32 cycles after CTRL entry
    busy_until = status_reads + 1000;
    data_val = 32'hFFFF_FFFF;
    push_bus(1'b1, BASE + 32'h4, 1);
    for (int r = 2; r <= 32; r += 5) push_bus(1'b0, BASE, r);
    push_rsp(1'b1, 32'h1234_5678, 5'd30, 33);
    do_start(5'd30);
    wait_idle("t6", 100);
    check("t6_busy_after", 32'(pif.busy_o), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
